// File: rtl/ccsds_turbo_rx_sys_extract.sv
// rtl/ccsds_turbo_rx_sys_extract.sv - turbo coded-symbol frame delimiter and systematic byte packer
module ccsds_turbo_rx_sys_extract #(
    parameter int K       = 8160,
    parameter int RATE    = 2,
    parameter int GAP_MAX = 16
) (
    input  logic            clk_rd,
    input  logic            rst_n,
    input  logic [RATE-1:0] i_data,
    input  logic            i_data_valid,
    input  logic            i_alarm,
    output logic [7:0]      o_byte,
    output logic            o_byte_valid,
    output logic            o_sof,
    output logic            o_eof,
    output logic [15:0]     o_frame_cnt,
    output logic            o_frame_err,
    output logic            o_busy
);

    localparam int SW = $clog2(K + 4);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          frame_err_q, frame_err_d;

    logic sys_bit;
    logic gap_abort;

    assign sys_bit   = i_data[RATE-1];
    // The idle cycle that would bring gap_cnt to GAP_MAX is itself the abort cycle.
    assign gap_abort = !i_data_valid && (gap_cnt_q == 8'(GAP_MAX - 1));

    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        gap_cnt_d    = gap_cnt_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_data_valid && !i_alarm) begin
                    shreg_d   = {shreg_q[6:0], sys_bit};
                    sym_cnt_d = SW'(1);
                    bit_cnt_d = 3'd1;
                    gap_cnt_d = 8'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA, ST_TAIL: begin
                if (i_alarm || gap_abort) begin
                    frame_err_d = 1'b1;
                    sym_cnt_d   = '0;
                    bit_cnt_d   = 3'd0;
                    shreg_d     = 8'd0;
                    gap_cnt_d   = 8'd0;
                    state_d     = ST_IDLE;
                end else if (!i_data_valid) begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end else begin
                    gap_cnt_d = 8'd0;
                    sym_cnt_d = sym_cnt_q + SW'(1);
                    if (state_q == ST_DATA) begin
                        shreg_d   = {shreg_q[6:0], sys_bit};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_d       = {shreg_q[6:0], sys_bit};
                            byte_valid_d = 1'b1;
                            sof_d        = (sym_cnt_q == SW'(7));
                            eof_d        = (sym_cnt_q == SW'(K - 1));
                        end
                        if (sym_cnt_q == SW'(K - 1)) begin
                            state_d = ST_TAIL;
                        end
                    end else if (sym_cnt_q == SW'(K + 3)) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rd) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'd0;
            gap_cnt_q    <= 8'd0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_cnt_q  <= 16'd0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            gap_cnt_q    <= gap_cnt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_sof        = sof_q;
    assign o_eof        = eof_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_frame_err  = frame_err_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: doc/ccsds_turbo_rx_sys_extract.md
# ccsds_turbo_rx_sys_extract

Receive-side companion to the CCSDS turbo encoder top. It consumes the encoder's coded symbol stream (RATE bits per symbol, one frame = K information symbols + 4 termination symbols) in the clk_rd domain. It delimits frames, strips the parity and tail symbols, and packs the systematic bits into bytes with start/end-of-frame markers. It also counts good frames and flags aborted ones. Used as the loop-back checker and hard-decision data sink in encoder benches and on-board self-test.

## Interface
Parameters:
- K, 8160, information bits per frame; must be a multiple of 8.
- RATE, 2, bits per coded symbol (2..6).
- GAP_MAX, 16, consecutive idle cycles inside a frame that abort it (2..255).

Ports:
- clk_rd  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_data  in  RATE  coded symbol; i_data[RATE-1] is the systematic bit, the lower bits are parity and are ignored.
- i_data_valid  in  1  symbol qualifier, one symbol per cycle when high.
- i_alarm  in  1  encoder alarm; aborts the current frame.
- o_byte  out  8  packed systematic byte; first received bit in o_byte[7].
- o_byte_valid  out  1  one-cycle strobe for o_byte.
- o_sof  out  1  high with o_byte_valid on the first byte of a frame.
- o_eof  out  1  high with o_byte_valid on byte K/8-1.
- o_frame_cnt  out  16  completed-frame counter; wraps 0xFFFF->0.
- o_frame_err  out  1  one-cycle pulse on frame abort.
- o_busy  out  1  high while state is not IDLE.

## Operation
- States: IDLE, DATA, TAIL.
- Symbol counter sym_cnt is clog2(K+4) bits wide. Bit counter bit_cnt is 3 bits. The 8-bit shift register holds bits MSB-first. gap_cnt is 8 bits.
- IDLE transitions:
  - i_data_valid=1 and i_alarm=0: the symbol is frame symbol 0. Shift it in, set sym_cnt=1 and bit_cnt=1, go to DATA.
  - i_data_valid=0, or i_alarm=1: no action; the symbol is dropped.
- DATA, on each valid symbol:
  - Shift in i_data[RATE-1] and increment bit_cnt.
  - When bit_cnt wraps from 7: register o_byte={shreg[6:0],bit} and pulse o_byte_valid.
  - o_sof is set on the first byte of the frame (sym_cnt=7). o_eof is set on the last byte (sym_cnt=K-1).
  - After symbol K-1, go to TAIL.
- TAIL: consume 4 valid symbols with no output. On the 4th symbol, increment o_frame_cnt and go to IDLE. The next valid cycle starts a new frame, so back-to-back frames need zero idle cycles.
- Gap handling (DATA/TAIL):
  - gap_cnt increments on each cycle with i_data_valid=0 and clears on each valid cycle.
  - When gap_cnt reaches GAP_MAX: abort.
- Abort:
  - Pulse o_frame_err, discard the partial byte, clear the counters, go to IDLE.
  - o_frame_cnt is unchanged and no o_eof is emitted.
- i_alarm=1 in DATA/TAIL aborts the frame. Alarm takes priority over a simultaneous valid symbol, which is dropped.
- Gap abort and alarm abort in the same cycle produce a single o_frame_err pulse.
- Reset mid-frame: all state and outputs return to reset values; the partial frame is lost and no o_frame_err pulse is produced.

## Timing
- Reset values: o_byte=0, o_byte_valid=0, o_sof=0, o_eof=0, o_frame_cnt=0, o_frame_err=0, o_busy=0, state=IDLE.
- All outputs are registered.
- o_byte, o_byte_valid, o_sof and o_eof update on the same edge that samples the 8th bit of the byte, so they are visible one cycle after that symbol is presented.
- o_frame_cnt updates on the edge that samples the 4th tail symbol.
- o_frame_err updates on the abort edge.
- o_busy rises on the edge that samples symbol 0 and falls on the edge of frame completion or abort.
- There is no backpressure; the sink accepts one symbol per cycle indefinitely.
- Byte strobes are spaced at least 8 cycles apart.

## Test plan
- Reset check: hold rst_n=0 for 5 cycles with random i_data/i_data_valid -> every output is 0 and o_busy=0.
- Clean frame (K=16, RATE=2): feed 20 contiguous symbols with systematic bits 0xA5, 0x3C and tail bits 1111 -> bytes A5 (o_sof=1) and 3C (o_eof=1), o_frame_cnt=1, o_frame_err never asserted.
- Gaps (K=16, GAP_MAX=16):
  - valid low for 15 cycles after symbol 5 -> the frame still yields A5/3C.
  - valid low for 16 cycles -> one o_frame_err pulse, no o_eof, o_frame_cnt unchanged.
- Alarm: assert i_alarm together with valid at symbol 10 -> o_frame_err pulse and that symbol dropped. After the alarm is released, the next frame yields correct bytes and o_frame_cnt increments.
- Back-to-back and wrap: 3 frames with zero idle cycles -> 6 bytes in order and o_frame_cnt=3. Preload o_frame_cnt=0xFFFF via force -> the next completed frame wraps it to 0.
- Loop-back (K=8160, RATE=2) against the encoder top driven by the known source -> 1020 bytes per frame matching the source, o_eof on byte 1019, no o_frame_err. Repeat with RATE=3 to confirm the parity bits are ignored.
